// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register with an integrated load-use hazard unit.
// Captures the decoded control bundle, register operands, extended
// immediate, register specifiers, shift amount and PC+4 every rising edge.
// It also produces the Bubble / PCWrite / IFIDWrite controls that freeze the
// front end for exactly one cycle behind a load whose destination is read by
// the instruction in ID.
//
// Ports
//   CLK, Resetb             clock, synchronous active-low reset
//   Ctrl_ID[13:0]           decoder controls: [13] Jump [12] Branch
//                           [11] ALUSrc [10] UseShamt [9] MemToReg
//                           [8] RegWrite [7] MemRead [6] MemWrite
//                           [5] SignExtend [4:1] ALUOp [0] RegDst
//   RD1_ID, RD2_ID          register file operands
//   Imm16_ID                raw 16-bit immediate
//   Rs_ID, Rt_ID, Rd_ID     register specifiers
//   Shamt_ID                shift amount
//   PCPlus4_ID              PC+4 of the decoding instruction
//   Flush                   kill the instruction entering EX
//   *_EX                    registered copies (one cycle latency)
//   Bubble                  zero the decoder controls (stall cycle)
//   PCWrite, IFIDWrite      front-end write enables
//
// Optional feature (macro HAZARD_STATS_EN):
//   StallCount[15:0]        saturating count of stalls taken
//   FlushCount[15:0]        saturating count of cycles with Flush=1
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              Resetb,
    input  logic [13:0]       Ctrl_ID,
    input  logic [DATA_W-1:0] RD1_ID,
    input  logic [DATA_W-1:0] RD2_ID,
    input  logic [15:0]       Imm16_ID,
    input  logic [REG_AW-1:0] Rs_ID,
    input  logic [REG_AW-1:0] Rt_ID,
    input  logic [REG_AW-1:0] Rd_ID,
    input  logic [4:0]        Shamt_ID,
    input  logic [DATA_W-1:0] PCPlus4_ID,
    input  logic              Flush,
    output logic [13:0]       Ctrl_EX,
    output logic [DATA_W-1:0] RD1_EX,
    output logic [DATA_W-1:0] RD2_EX,
    output logic [DATA_W-1:0] Imm32_EX,
    output logic [REG_AW-1:0] Rs_EX,
    output logic [REG_AW-1:0] Rt_EX,
    output logic [REG_AW-1:0] Rd_EX,
    output logic [4:0]        Shamt_EX,
    output logic [DATA_W-1:0] PCPlus4_EX,
    output logic              Bubble,
    output logic              PCWrite,
    output logic              IFIDWrite
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       StallCount,
    output logic [15:0]       FlushCount
`endif
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LDSTALL = 1'b1
    } state_e;

    localparam int MEMREAD_BIT = 7;
    localparam int SIGNEXT_BIT = 5;

    state_e              state_q, state_d;
    logic [13:0]         ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   rd1_q, rd1_d;
    logic [DATA_W-1:0]   rd2_q, rd2_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0]   rs_q, rs_d;
    logic [REG_AW-1:0]   rt_q, rt_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [4:0]          shamt_q, shamt_d;
    logic [DATA_W-1:0]   pc4_q, pc4_d;

    logic hz;
    logic stall;

    // Load in EX whose destination is a source of the instruction in ID.
    // A load to $0 never creates a dependency.
    assign hz = ctrl_q[MEMREAD_BIT]
              & (rt_q != '0)
              & ((rt_q == Rs_ID) | (rt_q == Rt_ID));

    // Only RUN may take a stall, which caps every load at one stall cycle;
    // a flush kills the dependent instruction so no stall is needed.
    assign stall = (state_q == ST_RUN) & hz & ~Flush;

    assign Bubble    = ~Resetb | stall;
    assign PCWrite   = Resetb & ~stall;
    assign IFIDWrite = Resetb & ~stall;

    // NOTE: every signal written here gets a value on every path (defaults
    // first) so no latch is inferred; blocking '=' is correct in comb logic.
    always_comb begin
        state_d = ST_RUN;
        if (stall) begin
            state_d = ST_LDSTALL;
        end

        // Controls are zeroed here rather than trusting the decoder to
        // react to Bubble in time; data fields are don't-care when killed.
        ctrl_d = Ctrl_ID;
        if (Flush || Bubble) begin
            ctrl_d = '0;
        end

        rd1_d   = RD1_ID;
        rd2_d   = RD2_ID;
        rs_d    = Rs_ID;
        rt_d    = Rt_ID;
        rd_d    = Rd_ID;
        shamt_d = Shamt_ID;
        pc4_d   = PCPlus4_ID;

        if (Ctrl_ID[SIGNEXT_BIT]) begin
            imm_d = DATA_W'($signed(Imm16_ID));
        end else begin
            imm_d = DATA_W'(Imm16_ID);
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops sample
    // their inputs from the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Resetb) begin
            state_q <= ST_RUN;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            pc4_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            pc4_q   <= pc4_d;
        end
    end

    assign Ctrl_EX    = ctrl_q;
    assign RD1_EX     = rd1_q;
    assign RD2_EX     = rd2_q;
    assign Imm32_EX   = imm_q;
    assign Rs_EX      = rs_q;
    assign Rt_EX      = rt_q;
    assign Rd_EX      = rd_q;
    assign Shamt_EX   = shamt_q;
    assign PCPlus4_EX = pc4_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Both counters saturate at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (Flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Resetb) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    logic        CLK = 1'b0;
    logic        Resetb;
    logic [13:0] Ctrl_ID;
    logic [31:0] RD1_ID, RD2_ID, PCPlus4_ID;
    logic [15:0] Imm16_ID;
    logic [4:0]  Rs_ID, Rt_ID, Rd_ID, Shamt_ID;
    logic        Flush;
    logic [13:0] Ctrl_EX;
    logic [31:0] RD1_EX, RD2_EX, Imm32_EX, PCPlus4_EX;
    logic [4:0]  Rs_EX, Rt_EX, Rd_EX, Shamt_EX;
    logic        Bubble, PCWrite, IFIDWrite;
`ifdef HAZARD_STATS_EN
    logic [15:0] StallCount, FlushCount;
`endif

    int checks   = 0;
    int failures = 0;

    id_ex_stage_reg dut (
        .CLK(CLK), .Resetb(Resetb), .Ctrl_ID(Ctrl_ID),
        .RD1_ID(RD1_ID), .RD2_ID(RD2_ID), .Imm16_ID(Imm16_ID),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID), .Shamt_ID(Shamt_ID),
        .PCPlus4_ID(PCPlus4_ID), .Flush(Flush),
        .Ctrl_EX(Ctrl_EX), .RD1_EX(RD1_EX), .RD2_EX(RD2_EX),
        .Imm32_EX(Imm32_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
        .Shamt_EX(Shamt_EX), .PCPlus4_EX(PCPlus4_EX),
        .Bubble(Bubble), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite)
`ifdef HAZARD_STATS_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // Pipeline register contents seen from EX, plus "did the last cycle
    // stall" which is all that is needed to know whether a stall may occur.
    bit          m_valid = 1'b0;
    logic [13:0] m_ctrl;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc4;
    logic [4:0]  m_rs, m_rt, m_rd, m_sh;
    bit          m_stalled;
    int          m_sc, m_fc;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare current DUT outputs with the model, then advance the model
    // across the coming rising edge.
    task automatic model_step();
        bit depends, stall_now, bub;
        depends   = m_ctrl[7] && (m_rt != 0) && (m_rt == Rs_ID || m_rt == Rt_ID);
        stall_now = Resetb && !m_stalled && depends && !Flush;
        bub       = !Resetb || stall_now;
        if (m_valid) begin
            check("m_ctrl",   32'(Ctrl_EX),    32'(m_ctrl));
            check("m_rd1",    RD1_EX,          m_rd1);
            check("m_rd2",    RD2_EX,          m_rd2);
            check("m_imm",    Imm32_EX,        m_imm);
            check("m_rs",     32'(Rs_EX),      32'(m_rs));
            check("m_rt",     32'(Rt_EX),      32'(m_rt));
            check("m_rd",     32'(Rd_EX),      32'(m_rd));
            check("m_shamt",  32'(Shamt_EX),   32'(m_sh));
            check("m_pc4",    PCPlus4_EX,      m_pc4);
            check("m_bubble", 32'(Bubble),     32'(bub));
            check("m_pcw",    32'(PCWrite),    32'(!bub));
            check("m_ifidw",  32'(IFIDWrite),  32'(!bub));
`ifdef HAZARD_STATS_EN
            check("m_stallcnt", 32'(StallCount), 32'(m_sc));
            check("m_flushcnt", 32'(FlushCount), 32'(m_fc));
`endif
        end
        if (!Resetb) begin
            m_valid = 1'b1;
            m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc4 = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_sh = 0;
            m_stalled = 1'b0; m_sc = 0; m_fc = 0;
        end else begin
            m_ctrl = (Flush || stall_now) ? 14'h0 : Ctrl_ID;
            m_rd1 = RD1_ID; m_rd2 = RD2_ID; m_pc4 = PCPlus4_ID;
            m_rs = Rs_ID; m_rt = Rt_ID; m_rd = Rd_ID; m_sh = Shamt_ID;
            m_imm = Ctrl_ID[5] ? {{16{Imm16_ID[15]}}, Imm16_ID}
                               : {16'h0, Imm16_ID};
            m_stalled = stall_now;
            if (stall_now && m_sc < 65535) m_sc++;
            if (Flush && m_fc < 65535) m_fc++;
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next
    // falling edge.
    task automatic tick();
        #1;
        model_step();
        @(negedge CLK);
    endtask

    task automatic drive(input logic [13:0] ctrl, input logic [4:0] rs,
                         input logic [4:0] rt, input logic fl);
        Ctrl_ID    = ctrl;
        Rs_ID      = rs;
        Rt_ID      = rt;
        Rd_ID      = 5'($urandom);
        RD1_ID     = $urandom;
        RD2_ID     = $urandom;
        Imm16_ID   = 16'($urandom);
        Shamt_ID   = 5'($urandom);
        PCPlus4_ID = $urandom;
        Flush      = fl;
    endtask

    localparam logic [13:0] LW  = 14'h01A0; // MemRead+RegWrite+SignExtend
    localparam logic [13:0] ADD = 14'h0102;

    initial begin
        Resetb = 1'b0;
        drive(14'($urandom), 5'($urandom), 5'($urandom), 1'b0);
        @(negedge CLK);

        // Reset: two cycles with random inputs
        tick();
        drive(14'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
        tick();
        check("rst_ctrl",  32'(Ctrl_EX), 32'h0);
        check("rst_rd1",   RD1_EX, 32'h0);
        check("rst_imm",   Imm32_EX, 32'h0);
        check("rst_bub",   32'(Bubble), 32'h1);
        check("rst_pcw",   32'(PCWrite), 32'h0);
        check("rst_ifidw", 32'(IFIDWrite), 32'h0);
        Resetb = 1'b1;
        drive(14'h0, 5'd1, 5'd2, 1'b0);
        #1;
        check("rel_bub", 32'(Bubble), 32'h0);
        check("rel_pcw", 32'(PCWrite), 32'h1);
        tick();

        // Pass-through
        drive(ADD, 5'd1, 5'd2, 1'b0);
        RD1_ID = 32'h11; RD2_ID = 32'h22;
        tick();
        check("pt_ctrl", 32'(Ctrl_EX), 32'h0102);
        check("pt_rd1",  RD1_EX, 32'h11);
        check("pt_rd2",  RD2_EX, 32'h22);

        // Immediate extension
        drive(14'h0020, 5'd1, 5'd2, 1'b0);
        Imm16_ID = 16'h8001;
        tick();
        check("ext_sign", Imm32_EX, 32'hFFFF8001);
        drive(14'h0000, 5'd1, 5'd2, 1'b0);
        Imm16_ID = 16'h8001;
        tick();
        check("ext_zero", Imm32_EX, 32'h00008001);

        // Load-use: lw $8 then a reader of $8
        drive(LW, 5'd1, 5'd8, 1'b0);
        tick();
        drive(ADD, 5'd8, 5'd9, 1'b0);
        #1;
        check("lu_bub",   32'(Bubble), 32'h1);
        check("lu_pcw",   32'(PCWrite), 32'h0);
        check("lu_ifidw", 32'(IFIDWrite), 32'h0);
        tick();
        check("lu_ctrl0", 32'(Ctrl_EX), 32'h0);
        #1;
        check("lu_after_pcw", 32'(PCWrite), 32'h1);
        tick();

        // Load to $0 never stalls
        drive(LW, 5'd0, 5'd0, 1'b0);
        tick();
        drive(ADD, 5'd0, 5'd0, 1'b0);
        #1;
        check("r0_bub", 32'(Bubble), 32'h0);
        tick();

        // Flush beats the hazard
        drive(LW, 5'd1, 5'd8, 1'b0);
        tick();
        drive(ADD, 5'd8, 5'd3, 1'b1);
        #1;
        check("fl_bub", 32'(Bubble), 32'h0);
        check("fl_pcw", 32'(PCWrite), 32'h1);
        tick();
        check("fl_ctrl", 32'(Ctrl_EX), 32'h0);

        // Flush while in LDSTALL, then a fresh stall proves we are in RUN
        drive(LW, 5'd1, 5'd8, 1'b0);
        tick();
        drive(ADD, 5'd8, 5'd3, 1'b0);
        tick();
        drive(ADD, 5'd4, 5'd5, 1'b1);
        tick();
        check("fls_ctrl", 32'(Ctrl_EX), 32'h0);
        drive(LW, 5'd1, 5'd8, 1'b0);
        tick();
        drive(ADD, 5'd8, 5'd3, 1'b0);
        #1;
        check("fls_run_bub", 32'(Bubble), 32'h1);
        tick();

        // Randomized traffic with dense dependencies
        for (int i = 0; i < 3000; i++) begin
            logic [13:0] c;
            c = 14'($urandom);
            c[7] = ($urandom_range(1, 0) == 1);
            drive(c, 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                  ($urandom_range(7, 0) == 0));
            Resetb = ($urandom_range(63, 0) != 0);
            tick();
        end

`ifdef HAZARD_STATS_EN
        // Three stalls and two flushes after a reset
        Resetb = 1'b0;
        drive(14'h0, 5'd1, 5'd2, 1'b0);
        tick();
        Resetb = 1'b1;
        drive(LW, 5'd1, 5'd8, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(ADD, 5'd8, 5'd3, 1'b0); tick();
            drive((k < 2) ? LW : 14'h0, 5'd1, 5'd8, 1'b0); tick();
        end
        drive(14'h0, 5'd1, 5'd2, 1'b1); tick();
        drive(14'h0, 5'd1, 5'd2, 1'b1); tick();
        drive(14'h0, 5'd1, 5'd2, 1'b0);
        check("cnt_stall", 32'(StallCount), 32'd3);
        check("cnt_flush", 32'(FlushCount), 32'd2);

        // Saturation
        dut.stall_count_q = 16'hFFFF;
        m_sc = 65535;
        drive(LW, 5'd1, 5'd8, 1'b0); tick();
        drive(ADD, 5'd8, 5'd3, 1'b0); tick();
        drive(14'h0, 5'd1, 5'd2, 1'b0); tick();
        check("cnt_sat", 32'(StallCount), 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard unit.
- Sits directly downstream of the pipelined control decoder and captures its decoded control bundle together with register-file operands, immediate, register specifiers and PC+4.
- Generates the `Bubble` input the decoder consumes, and the PC / IF-ID write enables.
- Handles flush requests from branch/jump resolution.

Parameters:
- DATA_W, 32, datapath width (operands, immediate, PC).
- REG_AW, 5, register specifier width.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- Resetb  in  1  synchronous reset, active-low.
- Ctrl_ID  in  14  decoder outputs, packed: [13] Jump, [12] Branch, [11] ALUSrc, [10] UseShamt, [9] MemToReg, [8] RegWrite, [7] MemRead, [6] MemWrite, [5] SignExtend, [4:1] ALUOp, [0] RegDst.
- RD1_ID  in  DATA_W  register file read port 1.
- RD2_ID  in  DATA_W  register file read port 2.
- Imm16_ID  in  16  instruction[15:0].
- Rs_ID, Rt_ID, Rd_ID  in  REG_AW each  instruction register fields.
- Shamt_ID  in  5  instruction[10:6].
- PCPlus4_ID  in  DATA_W  PC+4 of the decoding instruction.
- Flush  in  1  branch taken or jump resolved; kill the instruction entering EX.
- Ctrl_EX  out  14  registered control bundle, same packing as Ctrl_ID.
- RD1_EX, RD2_EX  out  DATA_W  registered operands.
- Imm32_EX  out  DATA_W  registered extended immediate.
- Rs_EX, Rt_EX, Rd_EX  out  REG_AW  registered specifiers.
- Shamt_EX  out  5  registered shift amount.
- PCPlus4_EX  out  DATA_W  registered PC+4.
- Bubble  out  1  to decoder `bubble` input; forces all-zero controls.
- PCWrite  out  1  PC register write enable.
- IFIDWrite  out  1  IF/ID register write enable.

Behaviour:
- **Reset.** On a clock edge with Resetb=0, every registered output is cleared to 0 and the FSM enters RUN. While Resetb=0: Bubble=1, PCWrite=0, IFIDWrite=0.
- **Load-use hazard detect (combinational).**
  - `hz = Ctrl_EX[7] & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (Rt_EX == Rt_ID))`.
- **FSM states.**
  - **RUN.** If hz and !Flush: Bubble=1, PCWrite=0, IFIDWrite=0, next state LDSTALL. Otherwise Bubble=0, PCWrite=1, IFIDWrite=1, stay in RUN.
  - **LDSTALL.** Bubble=0, PCWrite=1, IFIDWrite=1 unconditionally. Next state is always RUN. This caps a load to exactly one stall cycle even if the specifiers still match.
- **Capture every edge (Resetb=1).**
  - If Flush or Bubble: Ctrl_EX <= 0. All data fields are captured normally; they are don't-care, since every control is 0.
  - Otherwise Ctrl_EX <= Ctrl_ID.
  - The register zeroes controls itself and does not rely on the decoder's delayed response to Bubble.
- **Immediate extension.**
  - Imm32_EX <= {{16{Imm16_ID[15]}}, Imm16_ID} when Ctrl_ID[5]=1.
  - Imm32_EX <= {16'h0, Imm16_ID} when Ctrl_ID[5]=0.
- **Simultaneous events.**
  - Flush has priority over hz: no stall is taken, the FSM stays in (or returns to) RUN, and Ctrl_EX <= 0.
  - Flush asserted in LDSTALL: Ctrl_EX <= 0, next state RUN.
- **Reset mid-stall.** Returns to RUN with all outputs 0. No stall state survives reset.
- **Register 0.** A load to $0 never stalls.
- **Latency.** Exactly one cycle ID to EX for all captured fields. Bubble/PCWrite/IFIDWrite are same-cycle combinational from the state and the current ID/EX contents.

Optional Feature:
- **Macro: HAZARD_STATS_EN.**
- **When defined:** adds two outputs.
  - StallCount [15:0] increments each cycle the FSM transitions RUN->LDSTALL.
  - FlushCount [15:0] increments each cycle Flush=1 with Resetb=1.
  - Both saturate at 16'hFFFF and clear on reset.
- **When undefined:** the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- **Reset.** Resetb=0 for 2 cycles with random inputs -> every output 0 except Bubble=1; PCWrite=0, IFIDWrite=0. After release with no hazard -> Bubble=0, PCWrite=1.
- **Pass-through.** Ctrl_ID=14'h0102 (RegWrite + ADD), RD1_ID=32'h11, RD2_ID=32'h22 -> next cycle Ctrl_EX=14'h0102, RD1_EX=32'h11, RD2_EX=32'h22.
- **Extension.** Imm16_ID=16'h8001 with Ctrl_ID[5]=1 -> Imm32_EX=32'hFFFF8001. Same Imm16_ID with Ctrl_ID[5]=0 -> Imm32_EX=32'h00008001.
- **Load-use.** lw into $8 captured (Ctrl_EX[7]=1, Rt_EX=8), next instruction Rs_ID=8:
  - Same cycle: Bubble=1, PCWrite=0, IFIDWrite=0.
  - Next edge: Ctrl_EX=0, state LDSTALL.
  - Following cycle: PCWrite=1.
  - A repeat with Rt_EX=0 -> no stall.
- **Flush priority.** hz true and Flush=1 in the same cycle -> Bubble=0, Ctrl_EX=0 next edge, state stays RUN. Flush asserted in LDSTALL -> RUN.
- **Counters (HAZARD_STATS_EN).** 3 load-use stalls and 2 flushes -> StallCount=3, FlushCount=2. Preload at 16'hFFFF and stall once more -> stays 16'hFFFF.
